// File: rtl/canvas_pkg.sv
// Shared types and default geometry for the canvas brush engine.
package canvas_pkg;

    localparam int unsigned DEF_GRID     = 28;
    localparam int unsigned DEF_CELL_PX  = 14;
    localparam int unsigned DEF_ORIGIN_X = 199;
    localparam int unsigned DEF_ORIGIN_Y = 43;
    localparam int unsigned DEF_POS_W    = 10;
    localparam int unsigned MODE_W       = 2;

    // Engine states: one write per stroke state, one column per CLEAR cycle
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CENTER = 3'd1,
        NB_L   = 3'd2,
        NB_R   = 3'd3,
        NB_U   = 3'd4,
        NB_D   = 3'd5,
        CLEAR  = 3'd6
    } brush_state_t;

    // Brush modes; MODE_RSVD behaves exactly like MODE_DRAW
    typedef enum logic [MODE_W-1:0] {
        MODE_DRAW  = 2'b00,
        MODE_ERASE = 2'b01,
        MODE_SOFT  = 2'b10,
        MODE_RSVD  = 2'b11
    } brush_mode_t;

endpackage

// File: rtl/canvas_px_to_cell.sv
// Maps one screen coordinate to a canvas cell index with an in-grid flag.
// Built as a threshold compare ladder so no divider is needed.
module canvas_px_to_cell
    import canvas_pkg::*;
#(
    parameter int unsigned POS_W   = DEF_POS_W,
    parameter int unsigned GRID    = DEF_GRID,
    parameter int unsigned CELL_PX = DEF_CELL_PX,
    parameter int unsigned ORIGIN  = 0,
    parameter int unsigned IDX_W   = (GRID > 1) ? $clog2(GRID) : 1
)(
    input  logic [POS_W-1:0] pos,
    output logic [IDX_W-1:0] cell_c,
    output logic             in_grid_c
);

    localparam int unsigned OFF_W = POS_W + 1;
    localparam int unsigned SPAN  = GRID * CELL_PX;

    logic [OFF_W-1:0] off;

    // Offset from origin, range check, and ladder of cell-boundary compares
    always_comb begin
        off       = {1'b0, pos} - OFF_W'(ORIGIN);
        in_grid_c = ({1'b0, pos} >= OFF_W'(ORIGIN)) && (off < OFF_W'(SPAN));
        cell_c    = '0;
        for (int unsigned k = 1; k < GRID; k++) begin
            if (off >= OFF_W'(k * CELL_PX)) begin
                cell_c = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/canvas_brush_engine.sv
// Brush engine: accepts cursor strokes and paints a GRID x GRID canvas with
// draw / erase / soft-draw brushes, plus a column-serial clear.
module canvas_brush_engine
    import canvas_pkg::*;
#(
    parameter int unsigned GRID     = DEF_GRID,
    parameter int unsigned CELL_PX  = DEF_CELL_PX,
    parameter int unsigned ORIGIN_X = DEF_ORIGIN_X,
    parameter int unsigned ORIGIN_Y = DEF_ORIGIN_Y,
    parameter int unsigned PIX_W    = 16,
    parameter int unsigned INC      = 500,
    parameter int unsigned NB_INC   = 250,
    parameter int unsigned VMAX     = 2047
)(
    input  logic             frame_clk,
    input  logic             Reset_n,
    input  logic [9:0]       X_Pos,
    input  logic [9:0]       Y_Pos,
    input  logic [1:0]       Mode,
    input  logic             Stroke_Valid,
    output logic             Stroke_Ready,
    input  logic             Clear_Req,
    output logic             Busy,
    output logic [PIX_W-1:0] canvas [GRID][GRID]
);

    localparam int unsigned IDX_W = (GRID > 1) ? $clog2(GRID) : 1;
    localparam int unsigned POS_W = 10;

    brush_state_t     state, state_nxt;
    logic             clear_pend, clear_pend_nxt;
    logic [IDX_W-1:0] clr_col, clr_col_nxt;
    logic [IDX_W-1:0] cap_cx, cap_cy;
    brush_mode_t      cap_mode;
    logic             accept_c;

    logic [IDX_W-1:0] cell_x_c, cell_y_c;
    logic             in_x_c, in_y_c;

    logic [IDX_W-1:0] tgt_x, tgt_y, rd_x, rd_y;
    logic             wr_en;
    logic             erase;
    logic [PIX_W-1:0] step, cur_v, new_v;
    logic [PIX_W:0]   sum;

    canvas_px_to_cell #(
        .POS_W   (POS_W),
        .GRID    (GRID),
        .CELL_PX (CELL_PX),
        .ORIGIN  (ORIGIN_X),
        .IDX_W   (IDX_W)
    ) u_map_x (
        .pos       (X_Pos),
        .cell_c    (cell_x_c),
        .in_grid_c (in_x_c)
    );

    canvas_px_to_cell #(
        .POS_W   (POS_W),
        .GRID    (GRID),
        .CELL_PX (CELL_PX),
        .ORIGIN  (ORIGIN_Y),
        .IDX_W   (IDX_W)
    ) u_map_y (
        .pos       (Y_Pos),
        .cell_c    (cell_y_c),
        .in_grid_c (in_y_c)
    );

    // Next-state logic: pending clear wins over a stroke in IDLE
    always_comb begin
        state_nxt      = state;
        clear_pend_nxt = clear_pend | (Clear_Req && (state != CLEAR));
        clr_col_nxt    = clr_col;
        accept_c       = 1'b0;
        case (state)
            IDLE: begin
                if (clear_pend) begin
                    state_nxt      = CLEAR;
                    clear_pend_nxt = Clear_Req;
                    clr_col_nxt    = '0;
                end else if (Stroke_Valid && Stroke_Ready) begin
                    accept_c = 1'b1;
                    if (in_x_c && in_y_c) begin
                        state_nxt = CENTER;
                    end
                end
            end
            CENTER:  state_nxt = (cap_mode == MODE_SOFT) ? NB_L : IDLE;
            NB_L:    state_nxt = NB_R;
            NB_R:    state_nxt = NB_U;
            NB_U:    state_nxt = NB_D;
            NB_D:    state_nxt = IDLE;
            CLEAR: begin
                clr_col_nxt = clr_col + IDX_W'(1);
                if (clr_col == IDX_W'(GRID - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers; Busy/Stroke_Ready registered from next-state values
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            clear_pend   <= 1'b0;
            clr_col      <= '0;
            cap_cx       <= '0;
            cap_cy       <= '0;
            cap_mode     <= MODE_DRAW;
            Busy         <= 1'b0;
            Stroke_Ready <= 1'b1;
        end else begin
            state        <= state_nxt;
            clear_pend   <= clear_pend_nxt;
            clr_col      <= clr_col_nxt;
            Busy         <= (state_nxt != IDLE);
            Stroke_Ready <= (state_nxt == IDLE) && !clear_pend_nxt;
            if (accept_c) begin
                cap_cx   <= cell_x_c;
                cap_cy   <= cell_y_c;
                cap_mode <= brush_mode_t'(Mode);
            end
        end
    end

    // Target cell selection per stroke state; edge neighbours are skipped
    always_comb begin
        tgt_x = cap_cx;
        tgt_y = cap_cy;
        wr_en = 1'b0;
        erase = 1'b0;
        step  = PIX_W'(NB_INC);
        case (state)
            CENTER: begin
                wr_en = 1'b1;
                erase = (cap_mode == MODE_ERASE);
                step  = PIX_W'(INC);
            end
            NB_L: begin
                tgt_x = cap_cx - IDX_W'(1);
                wr_en = (cap_cx != '0);
            end
            NB_R: begin
                tgt_x = cap_cx + IDX_W'(1);
                wr_en = (cap_cx != IDX_W'(GRID - 1));
            end
            NB_U: begin
                tgt_y = cap_cy - IDX_W'(1);
                wr_en = (cap_cy != '0);
            end
            NB_D: begin
                tgt_y = cap_cy + IDX_W'(1);
                wr_en = (cap_cy != IDX_W'(GRID - 1));
            end
            default: ;
        endcase
    end

    // Shared saturating add / floor-at-zero subtract for every write state
    always_comb begin
        rd_x  = wr_en ? tgt_x : '0;
        rd_y  = wr_en ? tgt_y : '0;
        cur_v = canvas[rd_x][rd_y];
        sum   = {1'b0, cur_v} + {1'b0, step};
        if (erase) begin
            new_v = (cur_v >= PIX_W'(INC)) ? (cur_v - PIX_W'(INC)) : '0;
        end else begin
            new_v = (sum > (PIX_W + 1)'(VMAX)) ? PIX_W'(VMAX) : sum[PIX_W-1:0];
        end
    end

    // Canvas storage: async zero, column clear, or single-cell brush write
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int x = 0; x < GRID; x++) begin
                for (int y = 0; y < GRID; y++) begin
                    canvas[x][y] <= '0;
                end
            end
        end else if (state == CLEAR) begin
            for (int y = 0; y < GRID; y++) begin
                canvas[clr_col][y] <= '0;
            end
        end else if (wr_en) begin
            canvas[tgt_x][tgt_y] <= new_v;
        end
    end

endmodule
